// File: rtl/ldpc_pkg.sv
// Shared types and default geometry for the LDPC decoder control path.
package ldpc_pkg;

    localparam int LDPC_K        = 6;
    localparam int LDPC_J        = 3;
    localparam int LDPC_L        = 32;
    localparam int LDPC_PIPE_LAT = 4;
    localparam int LDPC_MAX_ITER = 8;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        CNP,
        CNP_DRAIN,
        VNP,
        DECIDE,
        OUTPUT
    } state_t;

endpackage

// File: rtl/ldpc_addr_counter.sv
// Wrapping 0..L-1 address counter with clear priority and terminal count.
module ldpc_addr_counter #(
    parameter int L          = 32,
    parameter int ADDR_WIDTH = $clog2(L)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic                  clr,
    output logic [ADDR_WIDTH-1:0] cnt,
    output logic                  tc
);

    assign tc = (cnt == ADDR_WIDTH'(L - 1));

    always_ff @(posedge clk) begin
        if (reset || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tc ? '0 : cnt + ADDR_WIDTH'(1);
        end
    end

endmodule

// File: rtl/ldpc_iter_ctrl.sv
// Frame/iteration sequencer for the block-parallel LDPC decoder.
// Define LDPC_EARLY_TERM_EN to enable parity-based early termination.
module ldpc_iter_ctrl
    import ldpc_pkg::*;
#(
    parameter int K          = LDPC_K,
    parameter int J          = LDPC_J,
    parameter int L          = LDPC_L,
    parameter int ADDR_WIDTH = $clog2(L),
    parameter int MAX_ITER   = LDPC_MAX_ITER,
    parameter int ITER_WIDTH = $clog2(MAX_ITER + 1),
    parameter int PIPE_LAT   = LDPC_PIPE_LAT
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ITER_WIDTH-1:0] max_iter_in,
    input  logic                  int_valid,
    input  logic [J*K-1:0]        p_bit,
    input  logic                  p_valid,
    output logic                  busy,
    output logic [ADDR_WIDTH-1:0] load_add,
    output logic                  cnu_rd_en,
    output logic [ADDR_WIDTH-1:0] cnu_rd_add,
    output logic                  cnu_wr_en,
    output logic [ADDR_WIDTH-1:0] cnu_wr_add,
    output logic                  vnu_en,
    output logic [ADDR_WIDTH-1:0] vnu_add,
    output logic [ADDR_WIDTH-1:0] read_add,
    output logic                  dec_valid,
    output logic                  f_id,
    output logic [ITER_WIDTH-1:0] iter_count,
    output logic                  converged,
    output logic                  done
);

    localparam int DW = $clog2(PIPE_LAT + 1);

    state_t                state;
    state_t                next_state;
    logic                  clr;
    logic                  step;
    logic [ADDR_WIDTH-1:0] cnt;
    logic                  tc;
    logic [DW-1:0]         drain_cnt;
    logic [ITER_WIDTH-1:0] cap;
    logic [ITER_WIDTH-1:0] cap_in;
    logic [ITER_WIDTH-1:0] iter_next;
    logic                  conv_now;
    logic [PIPE_LAT-1:0]   wr_en_sr;
    logic [ADDR_WIDTH-1:0] wr_add_sr [PIPE_LAT];

    ldpc_addr_counter #(
        .L         (L),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_cnt (
        .clk  (clk),
        .reset(reset),
        .en   (step),
        .clr  (clr),
        .cnt  (cnt),
        .tc   (tc)
    );

    assign iter_next = iter_count + ITER_WIDTH'(1);

    always_comb begin
        if (max_iter_in == '0) begin
            cap_in = ITER_WIDTH'(1);
        end else if (max_iter_in > ITER_WIDTH'(MAX_ITER)) begin
            cap_in = ITER_WIDTH'(MAX_ITER);
        end else begin
            cap_in = max_iter_in;
        end
    end

    always_comb begin
        next_state = state;
        step       = 1'b0;
        unique case (state)
            IDLE: if (start) next_state = LOAD;
            LOAD: begin
                step = int_valid;
                if (int_valid && tc) next_state = CNP;
            end
            CNP: begin
                step = 1'b1;
                if (tc) next_state = CNP_DRAIN;
            end
            CNP_DRAIN:
                if (drain_cnt == DW'(PIPE_LAT - 1)) next_state = VNP;
            VNP: begin
                step = 1'b1;
                if (tc) next_state = DECIDE;
            end
            DECIDE:
                next_state = (conv_now || iter_next == cap) ? OUTPUT : CNP;
            OUTPUT: begin
                step = 1'b1;
                if (tc) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
        clr = (next_state != state);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            f_id       <= 1'b0;
            iter_count <= '0;
            cap        <= '0;
            done       <= 1'b0;
            drain_cnt  <= '0;
        end else begin
            state     <= next_state;
            done      <= (state == OUTPUT) && tc;
            drain_cnt <= (state == CNP_DRAIN) ? drain_cnt + DW'(1) : '0;
            if (state == IDLE && start) begin
                f_id       <= ~f_id;
                iter_count <= '0;
                cap        <= cap_in;
            end else if (state == DECIDE) begin
                iter_count <= iter_next;
            end
        end
    end

    // Free-running write-back delay line; only reset clears it.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_en_sr <= '0;
            for (int i = 0; i < PIPE_LAT; i++) wr_add_sr[i] <= '0;
        end else begin
            wr_en_sr[0]  <= cnu_rd_en;
            wr_add_sr[0] <= cnu_rd_add;
            for (int i = 1; i < PIPE_LAT; i++) begin
                wr_en_sr[i]  <= wr_en_sr[i-1];
                wr_add_sr[i] <= wr_add_sr[i-1];
            end
        end
    end

`ifdef LDPC_EARLY_TERM_EN
    logic [J*K-1:0] syndrome;
    logic           conv_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            syndrome <= '0;
            conv_q   <= 1'b0;
        end else begin
            if (state == IDLE && start) begin
                conv_q <= 1'b0;
            end else if (state == DECIDE) begin
                conv_q <= ~|syndrome;
            end
            if (clr && next_state == CNP) begin
                syndrome <= '0;
            end else if ((state == CNP || state == CNP_DRAIN) && p_valid) begin
                syndrome <= syndrome | p_bit;
            end
        end
    end

    assign conv_now  = ~|syndrome;
    assign converged = conv_q;
`else
    logic unused_parity;
    assign unused_parity = ^{p_bit, p_valid};
    assign conv_now      = 1'b0;
    assign converged     = 1'b0;
`endif

    assign busy       = (state != IDLE);
    assign load_add   = (state == LOAD) ? cnt : '0;
    assign cnu_rd_en  = (state == CNP);
    assign cnu_rd_add = (state == CNP) ? cnt : '0;
    assign cnu_wr_en  = wr_en_sr[PIPE_LAT-1];
    assign cnu_wr_add = wr_add_sr[PIPE_LAT-1];
    assign vnu_en     = (state == VNP);
    assign vnu_add    = (state == VNP) ? cnt : '0;
    assign dec_valid  = (state == OUTPUT);
    assign read_add   = (state == OUTPUT) ? cnt : '0;

endmodule
